// File: rtl/sram_port_arbiter.sv
// -----------------------------------------------------------------------------
// sram_port_arbiter
//
// Shares one single-ported SRAM between an instruction-fetch port and a
// load/store port. Both masters use a req/addr_ok/data_ok handshake: the
// address phase is granted combinationally in the request cycle, and the
// response (read data or store completion) comes back exactly one cycle
// later. One access per cycle can be sustained back to back.
//
// Arbitration: data wins over instruction, except that after STARVE_MAX
// consecutive data grants taken while a fetch was waiting, the fetch wins.
//
// Parameters
//   STARVE_MAX      consecutive data grants allowed while a fetch waits (1-15)
//
// Ports
//   clk, resetn                      clock, asynchronous active-low reset
//   inst_req/inst_addr               fetch request (held until inst_addr_ok)
//   inst_addr_ok/inst_data_ok        fetch accepted / fetch data valid
//   inst_rdata                       fetch read data (0 unless inst_data_ok)
//   data_req/data_we/data_addr/
//   data_wdata                       load/store request (held until data_addr_ok)
//   data_addr_ok/data_data_ok        load/store accepted / completed
//   data_rdata                       load data (0 unless data_data_ok)
//   sram_en/sram_we/sram_addr/
//   sram_wdata                       shared SRAM command (all 0 when idle)
//   sram_rdata                       SRAM read data, one cycle after sram_en
//   inst_grant_cnt/data_grant_cnt    free-running accepted-request counters
// -----------------------------------------------------------------------------
module sram_port_arbiter #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        resetn,
    // instruction-fetch port
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    // load/store port
    input  logic        data_req,
    input  logic        data_we,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    // shared SRAM
    output logic        sram_en,
    output logic        sram_we,
    output logic [31:0] sram_addr,
    output logic [31:0] sram_wdata,
    input  logic [31:0] sram_rdata,
    // statistics
    output logic [31:0] inst_grant_cnt,
    output logic [31:0] data_grant_cnt
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    typedef enum logic {
        OWNER_INST = 1'b0,
        OWNER_DATA = 1'b1
    } owner_e;

    logic        inst_gnt_s;
    logic        data_gnt_s;

    logic        rsp_valid_q;
    logic        rsp_valid_d;
    owner_e      rsp_owner_q;
    owner_e      rsp_owner_d;
    logic [3:0]  starve_q;
    logic [3:0]  starve_d;
    logic [31:0] inst_grant_cnt_q;
    logic [31:0] inst_grant_cnt_d;
    logic [31:0] data_grant_cnt_q;
    logic [31:0] data_grant_cnt_d;

    // Grant decision; gated by resetn so nothing is accepted while in reset.
    always_comb begin
        inst_gnt_s = 1'b0;
        data_gnt_s = 1'b0;
        if (!resetn) begin
            inst_gnt_s = 1'b0;
            data_gnt_s = 1'b0;
        end else if (inst_req && (!data_req || (starve_q == STARVE_LIM))) begin
            // fetch wins when alone, or when it has waited out its budget
            inst_gnt_s = 1'b1;
        end else if (data_req) begin
            data_gnt_s = 1'b1;
        end else begin
            inst_gnt_s = 1'b0;
            data_gnt_s = 1'b0;
        end
    end

    assign inst_addr_ok = inst_gnt_s;
    assign data_addr_ok = data_gnt_s;

    // SRAM command mux: steer the granted requester onto the bus, else all 0.
    always_comb begin
        sram_en    = 1'b0;
        sram_we    = 1'b0;
        sram_addr  = 32'h0000_0000;
        sram_wdata = 32'h0000_0000;
        case ({inst_gnt_s, data_gnt_s})
            2'b10: begin
                sram_en    = 1'b1;
                sram_we    = 1'b0;
                sram_addr  = inst_addr;
                sram_wdata = 32'h0000_0000;
            end
            2'b01: begin
                sram_en    = 1'b1;
                sram_we    = data_we;
                sram_addr  = data_addr;
                sram_wdata = data_wdata;
            end
            default: begin
                sram_en    = 1'b0;
                sram_we    = 1'b0;
                sram_addr  = 32'h0000_0000;
                sram_wdata = 32'h0000_0000;
            end
        endcase
    end

    // Next-state for response tracking, starvation counter and statistics.
    always_comb begin
        rsp_valid_d      = inst_gnt_s | data_gnt_s;
        rsp_owner_d      = data_gnt_s ? OWNER_DATA : OWNER_INST;
        inst_grant_cnt_d = inst_grant_cnt_q + {31'd0, inst_gnt_s};
        data_grant_cnt_d = data_grant_cnt_q + {31'd0, data_gnt_s};
        starve_d         = starve_q;
        // The counter only measures an unbroken wait by the fetch port.
        if (!inst_req || inst_gnt_s) begin
            starve_d = 4'd0;
        end else if (data_gnt_s && (starve_q < STARVE_LIM)) begin
            starve_d = starve_q + 4'd1;
        end else begin
            starve_d = starve_q;
        end
    end

    // State registers; reset discards any access that is in flight.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rsp_valid_q      <= 1'b0;
            rsp_owner_q      <= OWNER_INST;
            starve_q         <= 4'd0;
            inst_grant_cnt_q <= 32'd0;
            data_grant_cnt_q <= 32'd0;
        end else begin
            rsp_valid_q      <= rsp_valid_d;
            rsp_owner_q      <= rsp_owner_d;
            starve_q         <= starve_d;
            inst_grant_cnt_q <= inst_grant_cnt_d;
            data_grant_cnt_q <= data_grant_cnt_d;
        end
    end

    // Response routing: the SRAM data arriving now belongs to last cycle's owner.
    always_comb begin
        inst_data_ok = 1'b0;
        data_data_ok = 1'b0;
        inst_rdata   = 32'h0000_0000;
        data_rdata   = 32'h0000_0000;
        if (rsp_valid_q) begin
            case (rsp_owner_q)
                OWNER_INST: begin
                    inst_data_ok = 1'b1;
                    inst_rdata   = sram_rdata;
                end
                OWNER_DATA: begin
                    data_data_ok = 1'b1;
                    data_rdata   = sram_rdata;
                end
                default: begin
                    inst_data_ok = 1'b0;
                    data_data_ok = 1'b0;
                end
            endcase
        end else begin
            inst_data_ok = 1'b0;
            data_data_ok = 1'b0;
        end
    end

    assign inst_grant_cnt = inst_grant_cnt_q;
    assign data_grant_cnt = data_grant_cnt_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// -----------------------------------------------------------------------------
// Self-checking bench for sram_port_arbiter. A transaction driver feeds two
// request queues with the hold-until-addr_ok protocol; a monitor runs a
// reference arbitration model, pushes expected responses into scoreboard
// queues at grant time and pops/compares them when data_ok arrives.
// -----------------------------------------------------------------------------
module tb_sram_port_arbiter;

    localparam int STARVE_MAX = 4;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req;
    logic        data_we;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic        sram_en;
    logic        sram_we;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;
    logic [31:0] inst_grant_cnt;
    logic [31:0] data_grant_cnt;

    sram_port_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .inst_req      (inst_req),
        .inst_addr     (inst_addr),
        .inst_addr_ok  (inst_addr_ok),
        .inst_data_ok  (inst_data_ok),
        .inst_rdata    (inst_rdata),
        .data_req      (data_req),
        .data_we       (data_we),
        .data_addr     (data_addr),
        .data_wdata    (data_wdata),
        .data_addr_ok  (data_addr_ok),
        .data_data_ok  (data_data_ok),
        .data_rdata    (data_rdata),
        .sram_en       (sram_en),
        .sram_we       (sram_we),
        .sram_addr     (sram_addr),
        .sram_wdata    (sram_wdata),
        .sram_rdata    (sram_rdata),
        .inst_grant_cnt(inst_grant_cnt),
        .data_grant_cnt(data_grant_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } dtx_t;

    int           n_assert = 0;
    int           n_fail   = 0;
    logic [31:0]  inst_txq[$];
    dtx_t         data_txq[$];
    logic [31:0]  exp_i_q[$];
    logic [32:0]  exp_d_q[$];   // {is_store, expected rdata}
    logic         pend_i = 1'b0;
    logic         pend_d = 1'b0;
    logic         i_acc  = 1'b0;
    logic         d_acc  = 1'b0;
    int           m_starve = 0;
    logic [31:0]  m_icnt = 32'd0;
    logic [31:0]  m_dcnt = 32'd0;
    logic [63:0]  glog = 64'd0;
    logic         mon_cnt_en = 1'b1;

    // SRAM contents as seen by reads: a fixed function of the address.
    function automatic logic [31:0] pat(input logic [31:0] a);
        if (a == 32'h1C00_0000) return 32'h0280_0000;
        return {a[15:0], a[31:16]} ^ 32'h3C3C_A5A5;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // SRAM responder: read data one cycle after the enable cycle, garbage otherwise.
    always @(posedge clk)
        sram_rdata <= (sram_en && !sram_we) ? pat(sram_addr) : 32'hBAD0_0BAD;

    // Monitor + reference model, sampled mid-cycle away from both edges.
    always @(negedge clk) begin
        logic        e_ig, e_dg;
        logic [32:0] ent;
        #2;
        if (!resetn) begin
            check("rst_ctl", {58'd0, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, sram_en, sram_we}, 64'd0);
            check("rst_bus", {sram_addr, sram_wdata}, 64'd0);
            check("rst_rdata", {inst_rdata, data_rdata}, 64'd0);
            check("rst_cnt", {inst_grant_cnt, data_grant_cnt}, 64'd0);
            m_starve = 0; m_icnt = 32'd0; m_dcnt = 32'd0;
            pend_i = 1'b0; pend_d = 1'b0; i_acc = 1'b0; d_acc = 1'b0;
            exp_i_q.delete(); exp_d_q.delete();
        end else begin
            e_ig = inst_req && (!data_req || (m_starve == STARVE_MAX));
            e_dg = data_req && !e_ig;
            check("inst_addr_ok", {63'd0, inst_addr_ok}, {63'd0, e_ig});
            check("data_addr_ok", {63'd0, data_addr_ok}, {63'd0, e_dg});
            check("sram_en_we", {62'd0, sram_en, sram_we}, {62'd0, e_ig | e_dg, e_dg & data_we});
            check("sram_addr", {32'd0, sram_addr}, {32'd0, e_ig ? inst_addr : (e_dg ? data_addr : 32'd0)});
            check("sram_wdata", {32'd0, sram_wdata}, {32'd0, e_dg ? data_wdata : 32'd0});
            i_acc = inst_addr_ok;
            d_acc = data_addr_ok;
            if (inst_addr_ok) glog = {glog[61:0], 2'b01};
            if (data_addr_ok) glog = {glog[61:0], 2'b10};
            check("inst_data_ok", {63'd0, inst_data_ok}, {63'd0, pend_i});
            check("data_data_ok", {63'd0, data_data_ok}, {63'd0, pend_d});
            if (pend_i) check("inst_rdata", {32'd0, inst_rdata}, {32'd0, exp_i_q.pop_front()});
            else        check("inst_rdata_idle", {32'd0, inst_rdata}, 64'd0);
            if (pend_d) begin
                ent = exp_d_q.pop_front();
                if (!ent[32]) check("data_rdata", {32'd0, data_rdata}, {32'd0, ent[31:0]});
            end else begin
                check("data_rdata_idle", {32'd0, data_rdata}, 64'd0);
            end
            if (mon_cnt_en) check("grant_cnts", {inst_grant_cnt, data_grant_cnt}, {m_icnt, m_dcnt});
            pend_i = e_ig;
            pend_d = e_dg;
            if (e_ig) begin exp_i_q.push_back(pat(inst_addr)); m_icnt = m_icnt + 32'd1; end
            if (e_dg) begin exp_d_q.push_back({data_we, pat(data_addr)}); m_dcnt = m_dcnt + 32'd1; end
            if (!inst_req || e_ig)                  m_starve = 0;
            else if (e_dg && m_starve < STARVE_MAX) m_starve = m_starve + 1;
        end
    end

    // Advance one cycle: retire accepted requests, present the next ones.
    task automatic step();
        @(negedge clk);
        if (inst_req && i_acc) void'(inst_txq.pop_front());
        if (data_req && d_acc) void'(data_txq.pop_front());
        if (inst_txq.size() > 0) begin
            inst_req  = 1'b1;
            inst_addr = inst_txq[0];
        end else begin
            inst_req  = 1'b0;
            inst_addr = 32'd0;
        end
        if (data_txq.size() > 0) begin
            data_req   = 1'b1;
            data_we    = data_txq[0].we;
            data_addr  = data_txq[0].addr;
            data_wdata = data_txq[0].wdata;
        end else begin
            data_req   = 1'b0;
            data_we    = 1'b0;
            data_addr  = 32'd0;
            data_wdata = 32'd0;
        end
    endtask

    task automatic wait_idle(input int budget);
        bit done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            step();
            if (inst_txq.size() == 0 && data_txq.size() == 0 && !inst_req && !data_req && !pend_i && !pend_d)
                done = 1'b1;
        end
        check("idle_timeout", {63'd0, done}, 64'd1);
    endtask

    // Called right after a negedge: abort traffic and hold reset for n cycles.
    task automatic apply_reset(input int n);
        inst_txq.delete();
        data_txq.delete();
        inst_req = 1'b0;
        data_req = 1'b0;
        resetn   = 1'b0;
        repeat (n) step();
        #3;
        check("rst_starve", {60'd0, dut.starve_q}, 64'd0);
        step();
        resetn = 1'b1;
    endtask

    function automatic dtx_t mk(input logic we, input logic [31:0] a, input logic [31:0] w);
        dtx_t t;
        t.we = we; t.addr = a; t.wdata = w;
        return t;
    endfunction

    initial begin
        logic [63:0] exp_log;
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] exp_log;
        // Reset with both requests asserted: everything must stay 0.
        resetn = 1'b0;
        inst_req = 1'b1; inst_addr = 32'h0000_1000;
        data_req = 1'b1; data_we = 1'b1; data_addr = 32'h0000_2000; data_wdata = 32'h1234_5678;
        repeat (3) @(negedge clk);
        inst_req = 1'b0; data_req = 1'b0;
        step();
        resetn = 1'b1;

        // Single fetch.
        inst_txq.push_back(32'h1C00_0000);
        wait_idle(20);
        check("fetch_cnt", {32'd0, inst_grant_cnt}, 64'd1);

        // Conflict: store first, then the fetch.
        glog = 64'd0;
        inst_txq.push_back(32'h1C00_0004);
        data_txq.push_back(mk(1'b1, 32'h0000_0100, 32'hDEAD_BEEF));
        wait_idle(20);
        check("conflict_order", glog, 64'b1001);

        // Starvation: 8 loads against a waiting fetch.
        glog = 64'd0;
        inst_txq.push_back(32'h1C00_0008);
        for (int i = 0; i < 8; i++) data_txq.push_back(mk(1'b0, 32'h0000_4000 + 32'(i * 4), 32'd0));
        wait_idle(40);
        exp_log = 64'd0;
        for (int i = 0; i < 9; i++) exp_log = {exp_log[61:0], (i == 4) ? 2'b01 : 2'b10};
        check("starve_order", glog, exp_log);

        // Streaming: 8 back-to-back loads.
        glog = 64'd0;
        for (int i = 0; i < 8; i++) data_txq.push_back(mk(1'b0, 32'h0000_8000 + 32'(i * 4), 32'd0));
        wait_idle(40);
        check("stream_order", glog, 64'hAAAA);

        // Random mix.
        for (int i = 0; i < 30; i++) begin
            case ($urandom_range(0, 2))
                0:       inst_txq.push_back($urandom() & 32'hFFFF_FFFC);
                1:       data_txq.push_back(mk(1'b0, $urandom() & 32'hFFFF_FFFC, $urandom()));
                default: data_txq.push_back(mk(1'b1, $urandom() & 32'hFFFF_FFFC, $urandom()));
            endcase
        end
        wait_idle(300);

        // Reset while a fetch is waiting on two data grants.
        inst_txq.push_back(32'h1C00_0010);
        for (int i = 0; i < 3; i++) data_txq.push_back(mk(1'b0, 32'h0000_C000 + 32'(i * 4), 32'd0));
        step();
        step();
        step();
        #3;
        check("starve_pre_rst", {60'd0, dut.starve_q}, 64'd2);
        @(negedge clk);
        apply_reset(2);
        wait_idle(10);

        // Reset in the cycle after a fetch grant: its data_ok must never show.
        inst_txq.push_back(32'h1C00_0000);
        step();
        step();
        apply_reset(2);
        repeat (4) step();

        // Counter wrap: preset to all-ones, next grant rolls over to 0.
        mon_cnt_en = 1'b0;
        force dut.data_grant_cnt_q = 32'hFFFF_FFFF;
        data_txq.push_back(mk(1'b0, 32'h0000_0040, 32'd0));
        step();
        #3;
        check("cnt_wrap", {32'd0, dut.data_grant_cnt_d}, 64'd0);
        wait_idle(10);
        release dut.data_grant_cnt_q;
        @(negedge clk);
        apply_reset(1);
        mon_cnt_en = 1'b1;
        inst_txq.push_back(32'h1C00_0020);
        wait_idle(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_port_arbiter.md
SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

Interface
REQ-001 The block SHALL have parameter STARVE_MAX, default 4, giving the maximum consecutive data grants while an instruction request waits (range 1-15).
REQ-002 The block SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 The block SHALL have port resetn  input  1  asynchronous active-low reset.
REQ-004 The block SHALL have port inst_req  input  1  instruction-fetch read request, held until inst_addr_ok.
REQ-005 The block SHALL have port inst_addr  input  32  fetch address.
REQ-006 The block SHALL have port inst_addr_ok  output  1  fetch request accepted this cycle.
REQ-007 The block SHALL have port inst_data_ok  output  1  fetch read data valid this cycle.
REQ-008 The block SHALL have port inst_rdata  output  32  fetch read data.
REQ-009 The block SHALL have port data_req  input  1  load/store request, held until data_addr_ok.
REQ-010 The block SHALL have port data_we  input  1  1 = store, 0 = load.
REQ-011 The block SHALL have port data_addr  input  32  load/store address.
REQ-012 The block SHALL have port data_wdata  input  32  store data.
REQ-013 The block SHALL have port data_addr_ok  output  1  load/store accepted this cycle.
REQ-014 The block SHALL have port data_data_ok  output  1  load data valid or store complete this cycle.
REQ-015 The block SHALL have port data_rdata  output  32  load data.
REQ-016 The block SHALL have port sram_en  output  1  shared SRAM access enable.
REQ-017 The block SHALL have port sram_we  output  1  shared SRAM write enable.
REQ-018 The block SHALL have port sram_addr  output  32  shared SRAM address.
REQ-019 The block SHALL have port sram_wdata  output  32  shared SRAM write data.
REQ-020 The block SHALL have port sram_rdata  input  32  shared SRAM read data, valid one cycle after the sram_en cycle.
REQ-021 The block SHALL have ports inst_grant_cnt and data_grant_cnt  output  32 each  accepted-request counters.

Function
REQ-022 Grant SHALL be combinational in the request cycle; at most one of inst_addr_ok/data_addr_ok SHALL be high per cycle.
REQ-023 Priority SHALL be data over inst, except inst wins when inst_req=1 and starve_cnt==STARVE_MAX.
REQ-024 On a grant, sram_en=1 and sram_addr and sram_wdata SHALL be driven from the granted requester; sram_we=data_we on data grants and 0 on inst grants.
REQ-025 With no grant, sram_en, sram_we, sram_addr and sram_wdata SHALL all be 0.
REQ-026 Response stage: registers rsp_valid and rsp_owner SHALL capture the grant; the owner's data_ok SHALL assert exactly one cycle after its addr_ok, with rdata = sram_rdata.
REQ-027 A store SHALL produce data_data_ok one cycle after acceptance; data_rdata is don't-care for stores.
REQ-028 Back-to-back grants SHALL be allowed: a new grant may occur in the same cycle as the previous data_ok, sustaining one access per cycle.
REQ-029 inst_rdata/data_rdata SHALL equal sram_rdata when the matching data_ok is high, else 0.
REQ-030 starve_cnt (4 bits): +1 on a data grant while inst_req=1, saturating at STARVE_MAX; cleared on an inst grant or any cycle with inst_req=0.
REQ-031 Grant counters SHALL increment by 1 per accepted request of their requester and wrap from 0xFFFFFFFF to 0.
REQ-032 A requester dropping req before addr_ok is illegal; behaviour is undefined.

Reset
REQ-033 resetn=0 SHALL immediately clear rsp_valid, rsp_owner, starve_cnt and both grant counters, and force all addr_ok, data_ok, rdata and sram_* outputs to 0 regardless of requests.
REQ-034 An access in flight at reset SHALL be discarded, with no data_ok after reset release.
REQ-035 Grants SHALL resume on the first rising edge with resetn=1.

Verification
REQ-036 Single fetch: inst_req=1, inst_addr=0x1C000000, sram_rdata=0x02800000 next cycle -> inst_addr_ok in cycle 0, inst_data_ok with inst_rdata=0x02800000 in cycle 1, inst_grant_cnt=1.
REQ-037 Conflict: inst_req and data_req both held, data_we=1, addr 0x100, wdata 0xDEADBEEF -> data granted first with sram_we=1, sram_wdata=0xDEADBEEF; inst granted next cycle.
REQ-038 Starvation: data_req held continuously, inst_req held, STARVE_MAX=4 -> 4 data grants, then 1 inst grant on the 5th cycle, then data resumes.
REQ-039 Streaming: 8 consecutive loads -> 8 data_addr_ok in cycles 0-7 and data_data_ok in cycles 1-8, no bubbles.
REQ-040 Mid-flight reset: resetn=0 in the cycle after an inst grant -> inst_data_ok never asserts, and counters and starve_cnt read 0.
REQ-041 Counter wrap: data_grant_cnt preset via 2^32-1 grants (or forced) -> the next grant gives 0.
